gpio_in_debounce: RTL and testbench
===================================

Name: gpio_in_debounce

Overview:
- Input conditioning stage that sits directly upstream of the core's 8-bit GPIO input, ahead of the sign-extend.
- Takes raw, asynchronous board pins (switches and buttons) and synchronises each bit.
- Debounces each bit independently.
- Presents a glitch-free, clock-aligned byte on GPIO_i, plus a one-cycle change strobe for future interrupt or polling logic.

Parameters:
- WIDTH, 8: number of input pins handled.
- DEBOUNCE_CYCLES, 1000: consecutive clk cycles a synchronised bit must hold a new level before it is accepted. Legal range 1..65535.
- CNT_W, 16: width of each per-bit stability counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, shared with the core.
- rst  input  1  asynchronous, active-low reset.
- pins_i  input  WIDTH  raw asynchronous pin levels.
- GPIO_i  output  WIDTH  debounced stable value, fed to the core's GPIO input.
- change_o  output  1  one-cycle pulse when any GPIO_i bit updates.
- rise_o  output  WIDTH  one-cycle per-bit pulse on an accepted 0->1 transition.
- fall_o  output  WIDTH  one-cycle per-bit pulse on an accepted 1->0 transition.

Behaviour:
- Reset: rst=0 asynchronously clears sync stages, counters, per-bit FSMs, GPIO_i, change_o, rise_o and fall_o to 0. All outputs are registered.
- Synchroniser: two flops per bit (s1, s2); s2 is the synchronised level.
- Per-bit FSM, STABLE:
  - if s2 == GPIO_i[b], hold, counter = 0.
  - else go to COUNT, counter = 1.
- Per-bit FSM, COUNT:
  - if s2 == GPIO_i[b], bounce: abort to STABLE, counter = 0, GPIO_i unchanged.
  - else if counter == DEBOUNCE_CYCLES-1: next edge GPIO_i[b] <= s2, pulse rise_o[b] or fall_o[b] for one cycle, return to STABLE, counter = 0.
  - else counter += 1.
- DEBOUNCE_CYCLES == 1: COUNT is skipped. GPIO_i[b] updates on the cycle after s2 differs.
- Latency, clean pin step to GPIO_i change: 2 sync cycles + DEBOUNCE_CYCLES cycles. With DEBOUNCE_CYCLES=4 this is 6 rising edges after the pin edge is sampled.
- change_o = OR of rise_o and fall_o, registered in the same cycle as the GPIO_i update.
- Counters never exceed DEBOUNCE_CYCLES-1 and never wrap.
- Bits are fully independent. Simultaneous transitions on several bits in the same cycle update together and give a single change_o pulse.
- A pin toggling faster than DEBOUNCE_CYCLES never propagates; GPIO_i holds its last stable value indefinitely.
- Reset asserted mid-COUNT discards the pending transition. After release, GPIO_i=0, and a pin held high is accepted after the full latency.

Optional Feature:
- Macro: GPIO_EDGE_LATCH_EN.
- When defined, two extra ports are present:
  - clr_i  input  WIDTH: per-bit write-one-to-clear.
  - edge_o  output  WIDTH: sticky OR of rise_o|fall_o per bit.
- edge_o[b] sets on an accepted edge and clears when clr_i[b]=1.
- A set and a clear in the same cycle leave edge_o[b]=1 (set wins).
- Reset clears edge_o.
- Without the macro, neither port exists and there is no sticky logic.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with pins_i=8'hFF, release rst, hold pins -> GPIO_i=8'h00 until edge 6, then 8'hFF; rise_o=8'hFF and change_o=1 for exactly one cycle.
- pins_i[0] 0->1, held 3 cycles, back to 0 -> GPIO_i stays 8'h00; no rise_o/change_o pulses.
- pins_i[2] toggles every 2 cycles for 40 cycles, then settles at 1 -> GPIO_i[2]=1 exactly 6 cycles after settling, with a single rise_o[2] pulse.
- From GPIO_i=8'h0F, drive pins_i=8'hF0 in one step -> after 6 cycles GPIO_i=8'hF0, rise_o=8'hF0, fall_o=8'h0F, one change_o pulse.
- pins_i[5] rises, rst pulsed low at count 2 -> all outputs 0 immediately; GPIO_i[5]=1 six cycles after rst release.
- GPIO_EDGE_LATCH_EN: accepted rise on bit 3 -> edge_o=8'h08. clr_i=8'h08 -> edge_o=8'h00. clr_i held during a new edge -> edge_o[3]=1.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// Per-bit two-flop synchroniser and debouncer for raw GPIO pins, with registered rise/fall/change strobes.
// Optional sticky edge latch (clr_i / edge_o) is enabled by defining GPIO_EDGE_LATCH_EN.
module gpio_in_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_i,
`ifdef GPIO_EDGE_LATCH_EN
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] edge_o,
`endif
    output logic [WIDTH-1:0] GPIO_i,
    output logic             change_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] gpio_q;
    logic [WIDTH-1:0] gpio_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             change_q;
    logic             change_d;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= pins_i;
            s2_q <= s1_q;
        end
    end

    // Per-bit debounce FSM: a bit is accepted only after s2 differs from GPIO_i for DEBOUNCE_CYCLES cycles.
    always_comb begin
        gpio_d = gpio_q;
        rise_d = {WIDTH{1'b0}};
        fall_d = {WIDTH{1'b0}};
        for (int b = 0; b < WIDTH; b++) begin
            state_d[b] = ST_STABLE;
            cnt_d[b]   = {CNT_W{1'b0}};
            case (state_q[b])
                ST_STABLE: begin
                    if (s2_q[b] != gpio_q[b]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            gpio_d[b] = s2_q[b];
                            rise_d[b] = s2_q[b];
                            fall_d[b] = ~s2_q[b];
                        end else begin
                            state_d[b] = ST_COUNT;
                            cnt_d[b]   = CNT_ONE;
                        end
                    end else begin
                        state_d[b] = ST_STABLE;
                    end
                end
                ST_COUNT: begin
                    if (s2_q[b] == gpio_q[b]) begin
                        state_d[b] = ST_STABLE;
                    end else if (cnt_q[b] == CNT_MAX) begin
                        gpio_d[b] = s2_q[b];
                        rise_d[b] = s2_q[b];
                        fall_d[b] = ~s2_q[b];
                    end else begin
                        state_d[b] = ST_COUNT;
                        cnt_d[b]   = cnt_q[b] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[b] = ST_STABLE;
                end
            endcase
        end
        change_d = |(rise_d | fall_d);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < WIDTH; b++) begin
                state_q[b] <= ST_STABLE;
                cnt_q[b]   <= {CNT_W{1'b0}};
            end
            gpio_q   <= {WIDTH{1'b0}};
            rise_q   <= {WIDTH{1'b0}};
            fall_q   <= {WIDTH{1'b0}};
            change_q <= 1'b0;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            gpio_q   <= gpio_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign GPIO_i   = gpio_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = change_q;

`ifdef GPIO_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;

    // Sticky edge flags; a new edge wins over a simultaneous clear.
    always_comb begin
        edge_d = (edge_q & ~clr_i) | rise_d | fall_d;
    end

    // Edge flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= {WIDTH{1'b0}};
        end else begin
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed self-checking bench for gpio_in_debounce with DEBOUNCE_CYCLES=4 (pin step to GPIO_i in 6 edges).
module tb_gpio_in_debounce;

    localparam int W  = 8;
    localparam int DC = 4;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pins = 8'h00;
    logic [W-1:0] gpio;
    logic         change;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
`ifdef GPIO_EDGE_LATCH_EN
    logic [W-1:0] clr = 8'h00;
    logic [W-1:0] edge_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gpio_in_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pins_i   (pins),
`ifdef GPIO_EDGE_LATCH_EN
        .clr_i    (clr),
        .edge_o   (edge_flags),
`endif
        .GPIO_i   (gpio),
        .change_o (change),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] acc_g;
        logic [W-1:0] acc_r;
        logic         acc_c;
        int           n_chg;

        // Reset state with pins already high
        rst  = 1'b0;
        pins = 8'hFF;
        step(2);
        check_val("rst_gpio", 32'(gpio), 32'h00);
        check_val("rst_rise", 32'(rise), 32'h00);
        check_val("rst_fall", 32'(fall), 32'h00);
        check_val("rst_change", 32'(change), 32'h0);

        // Release: GPIO_i follows after exactly 6 edges
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k < 6) check_val("t1_hold", 32'(gpio), 32'h00);
        end
        check_val("t1_gpio", 32'(gpio), 32'hFF);
        check_val("t1_rise", 32'(rise), 32'hFF);
        check_val("t1_fall", 32'(fall), 32'h00);
        check_val("t1_change", 32'(change), 32'h1);
        step(1);
        check_val("t1_rise_end", 32'(rise), 32'h00);
        check_val("t1_change_end", 32'(change), 32'h0);
        check_val("t1_gpio_keep", 32'(gpio), 32'hFF);

        // Return to all-low
        pins = 8'h00;
        step(6);
        check_val("t1b_gpio", 32'(gpio), 32'h00);
        check_val("t1b_fall", 32'(fall), 32'hFF);
        check_val("t1b_change", 32'(change), 32'h1);
        step(1);

        // Short 3-cycle pulse on bit 0 is rejected
        pins  = 8'h01;
        acc_g = 8'h00;
        acc_r = 8'h00;
        acc_c = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (i == 2) pins = 8'h00;
            acc_g |= gpio;
            acc_r |= rise;
            acc_c |= change;
        end
        check_val("t2_gpio", 32'(acc_g), 32'h00);
        check_val("t2_rise", 32'(acc_r), 32'h00);
        check_val("t2_change", 32'(acc_c), 32'h0);

        // Bit 2 toggling every 2 cycles never propagates
        acc_g = 8'h00;
        acc_r = 8'h00;
        for (int i = 0; i < 20; i++) begin
            pins[2] = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                step(1);
                acc_g |= gpio;
                acc_r |= rise;
            end
        end
        check_val("t3_toggle_gpio", 32'(acc_g), 32'h00);
        check_val("t3_toggle_rise", 32'(acc_r), 32'h00);
        pins[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k < 6) check_val("t3_hold", 32'(gpio), 32'h00);
        end
        check_val("t3_gpio", 32'(gpio), 32'h04);
        check_val("t3_rise", 32'(rise), 32'h04);
        check_val("t3_change", 32'(change), 32'h1);
        step(1);
        check_val("t3_rise_end", 32'(rise), 32'h00);

        // Multi-bit simultaneous update 0F -> F0
        pins = 8'h0F;
        step(6);
        check_val("t4_pre", 32'(gpio), 32'h0F);
        step(1);
        pins  = 8'hF0;
        n_chg = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            n_chg += int'(change);
            if (k < 6) check_val("t4_hold", 32'(gpio), 32'h0F);
        end
        check_val("t4_gpio", 32'(gpio), 32'hF0);
        check_val("t4_rise", 32'(rise), 32'hF0);
        check_val("t4_fall", 32'(fall), 32'h0F);
        step(1);
        n_chg += int'(change);
        check_val("t4_change_cnt", 32'(n_chg), 32'd1);

        // Reset mid-count on bit 5 discards the pending transition
        pins = 8'h01;
        step(6);
        check_val("t5_pre", 32'(gpio), 32'h01);
        step(1);
        pins = 8'h21;
        step(4);
        rst = 1'b0;
        #1;
        check_val("t5_rst_gpio", 32'(gpio), 32'h00);
        check_val("t5_rst_rise", 32'(rise), 32'h00);
        check_val("t5_rst_change", 32'(change), 32'h0);
        step(2);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k < 6) check_val("t5_hold", 32'(gpio), 32'h00);
        end
        check_val("t5_gpio", 32'(gpio), 32'h21);
        check_val("t5_rise", 32'(rise), 32'h21);
        step(1);

`ifdef GPIO_EDGE_LATCH_EN
        // Sticky edge flags: clear, set on rise, clear, set wins over held clear
        clr = 8'hFF;
        step(1);
        clr = 8'h00;
        check_val("e_clear_all", 32'(edge_flags), 32'h00);
        pins = 8'h29;
        step(6);
        check_val("e_set", 32'(edge_flags), 32'h08);
        step(1);
        check_val("e_sticky", 32'(edge_flags), 32'h08);
        clr = 8'h08;
        step(1);
        check_val("e_clr", 32'(edge_flags), 32'h00);
        pins = 8'h21;
        step(6);
        check_val("e_set_wins", 32'(edge_flags), 32'h08);
        clr = 8'h00;
        step(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
